// File: rtl/bsg_tag_serial_driver_pkg.sv
// Shared types and helpers for the bsg_tag serial driver.
package bsg_tag_serial_driver_pkg;

   typedef enum logic [2:0] {
      eINIT_ONES,
      eINIT_ZEROS,
      eIDLE,
      eSHIFT,
      eGAP
   } bsg_tag_serial_state_e;

   // Packet layout for the default configuration (els_p=16 -> nw=4,
   // lg_width_p=4 -> 15-bit payload). Field order matches the wire order
   // read from MSB down: payload, len, data_not_reset, node_id.
   typedef struct packed {
      logic [14:0] payload;
      logic [3:0]  len;
      logic        data_not_reset;
      logic [3:0]  node_id;
   } bsg_tag_serial_pkt_s;

   // Header bits on the wire: start bit + node id + data_not_reset + len.
   function automatic int bsg_tag_serial_hdr_width(input int nw, input int lg_width);
      return 2 + nw + lg_width;
   endfunction

   function automatic int bsg_tag_serial_max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/bsg_tag_serial_driver.sv
// Serializes whole bsg_tag packets onto a single tag data line, one bit per
// clock, after emitting the tag master init pattern out of reset.
module bsg_tag_serial_driver
   import bsg_tag_serial_driver_pkg::*;
#(
   parameter int els_p        = 16,
   parameter int lg_width_p   = 4,
   parameter int init_ones_p  = 64,
   parameter int init_zeros_p = 16,
   parameter int gap_p        = 2,
   localparam int nw_lp       = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int mp_lp       = (1 << lg_width_p) - 1
)(
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  v_i,
   output logic                  ready_and_o,
   input  logic [nw_lp-1:0]      node_id_i,
   input  logic                  data_not_reset_i,
   input  logic [lg_width_p-1:0] len_i,
   input  logic [mp_lp-1:0]      payload_i,
   output logic                  tag_data_o,
   output logic                  init_done_o,
   output logic                  busy_o
);

   localparam int hdr_lp     = bsg_tag_serial_hdr_width(nw_lp, lg_width_p);
   localparam int sw_lp      = hdr_lp + mp_lp;
   localparam int cnt_max_lp = bsg_tag_serial_max4(init_ones_p, init_zeros_p, gap_p, sw_lp);
   localparam int cw_lp      = $clog2(cnt_max_lp) + 1;

   bsg_tag_serial_state_e r_state, w_state_next;
   logic [cw_lp-1:0]      r_cnt, w_cnt_next;
   logic [sw_lp-1:0]      r_shift, w_shift_next;
   logic                  r_tag, w_tag_next;
   logic                  r_init_done;
   logic                  r_busy;

   logic [mp_lp-1:0]      w_payload_masked;
   logic [sw_lp-1:0]      w_pkt;
   logic [cw_lp-1:0]      w_pkt_bits_m1;

   // Zero payload bits at or above len_i so stale upper bits never reach the shifter.
   for (genvar gi = 0; gi < mp_lp; gi++) begin : g_payload_mask
      assign w_payload_masked[gi] = payload_i[gi] & (lg_width_p'(gi) < len_i);
   end

   // Wire order, LSB first: start bit, node id, data_not_reset, len, payload.
   assign w_pkt         = {w_payload_masked, len_i, data_not_reset_i, node_id_i, 1'b1};
   assign w_pkt_bits_m1 = cw_lp'(hdr_lp - 1) + cw_lp'(len_i);

   // Next-state decode. The tag bit is computed here and registered, so the
   // registered output always reflects the state being entered.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_shift_next = r_shift;
      w_tag_next   = 1'b0;
      case (r_state)
         eINIT_ONES: begin
            // r_cnt counts ones already emitted
            if (r_cnt == cw_lp'(init_ones_p)) begin
               w_state_next = eINIT_ZEROS;
               w_cnt_next   = cw_lp'(init_zeros_p - 1);
            end else begin
               w_cnt_next = r_cnt + cw_lp'(1);
               w_tag_next = 1'b1;
            end
         end
         eINIT_ZEROS: begin
            if (r_cnt == '0) w_state_next = eIDLE;
            else             w_cnt_next   = r_cnt - cw_lp'(1);
         end
         eIDLE: begin
            // Start bit goes out on the accept edge; the rest stays queued.
            if (v_i) begin
               w_state_next = eSHIFT;
               w_shift_next = w_pkt >> 1;
               w_cnt_next   = w_pkt_bits_m1;
               w_tag_next   = w_pkt[0];
            end
         end
         eSHIFT: begin
            // r_cnt counts bits still to emit after the current one
            if (r_cnt != '0) begin
               w_tag_next   = r_shift[0];
               w_shift_next = r_shift >> 1;
               w_cnt_next   = r_cnt - cw_lp'(1);
            end else begin
               w_state_next = eGAP;
               w_cnt_next   = cw_lp'(gap_p - 1);
            end
         end
         eGAP: begin
            if (r_cnt == '0) w_state_next = eIDLE;
            else             w_cnt_next   = r_cnt - cw_lp'(1);
         end
         default: begin
            w_state_next = eINIT_ONES;
            w_cnt_next   = '0;
         end
      endcase
   end

   // State, counter, shifter and registered outputs; reset restarts the init pattern.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state     <= eINIT_ONES;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_tag       <= 1'b0;
         r_init_done <= 1'b0;
         r_busy      <= 1'b1;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_shift     <= w_shift_next;
         r_tag       <= w_tag_next;
         r_init_done <= r_init_done | (w_state_next == eIDLE);
         r_busy      <= (w_state_next != eIDLE);
      end
   end

   assign ready_and_o = (r_state == eIDLE);
   assign tag_data_o  = r_tag;
   assign init_done_o = r_init_done;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_bsg_tag_serial_driver.sv
// Directed bench for bsg_tag_serial_driver (els_p=4, lg_width_p=4, 8 ones, 4 zeros, gap 2).
module tb_bsg_tag_serial_driver;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        v;
   logic        ready;
   logic [1:0]  node_id;
   logic        dnr;
   logic [3:0]  len;
   logic [14:0] payload;
   logic        tag;
   logic        init_done;
   logic        busy;

   int n_vec       = 0;
   int n_miscompare = 0;

   always #5 clk = ~clk;

   bsg_tag_serial_driver #(
      .els_p        (4),
      .lg_width_p   (4),
      .init_ones_p  (8),
      .init_zeros_p (4),
      .gap_p        (2)
   ) dut (
      .clk_i            (clk),
      .reset_n_i        (reset_n),
      .v_i              (v),
      .ready_and_o      (ready),
      .node_id_i        (node_id),
      .data_not_reset_i (dnr),
      .len_i            (len),
      .payload_i        (payload),
      .tag_data_o       (tag),
      .init_done_o      (init_done),
      .busy_o           (busy)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscompare++;
         $display("FAIL %s: got %0h, expected %0h", name, obs, exp);
      end
   endtask

   // One clock edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From the first edge with reset released: 8 ones, 4 zeros, ready in cycle 13.
   task automatic check_init(input string name);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("%s_tag_c%0d", name, k), tag, (k <= 8) ? 1 : 0);
         chk($sformatf("%s_rdy_c%0d", name, k), ready, 0);
         chk($sformatf("%s_done_c%0d", name, k), init_done, 0);
      end
      tick();
      chk({name, "_rdy_c13"}, ready, 1);
      chk({name, "_done_c13"}, init_done, 1);
      chk({name, "_busy_c13"}, busy, 0);
      chk({name, "_tag_c13"}, tag, 0);
      $display("init %s: pattern checked", name);
   endtask

   // Called in the cycle showing bit 0; checks all bits, the gap, and ready return.
   task automatic check_stream(input string name, input logic [31:0] exp_bits, input int n);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_b%0d", name, i), tag, exp_bits[i]);
         chk($sformatf("%s_rdy_b%0d", name, i), ready, 0);
         chk($sformatf("%s_busy_b%0d", name, i), busy, 1);
         if (i < n - 1) tick();
      end
      for (int g = 0; g < 2; g++) begin
         tick();
         chk($sformatf("%s_gap%0d_tag", name, g), tag, 0);
         chk($sformatf("%s_gap%0d_rdy", name, g), ready, 0);
      end
      tick();
      chk({name, "_rdy_back"}, ready, 1);
      chk({name, "_tag_idle"}, tag, 0);
      chk({name, "_busy_idle"}, busy, 0);
      $display("pkt %s: %0d bits + gap checked", name, n);
   endtask

   task automatic drive(input logic [1:0] nid, input logic d, input logic [3:0] l, input logic [14:0] p);
      int w;
      w = 0;
      while (!ready && w < 40) begin
         tick();
         w++;
      end
      if (!ready) chk("rdy_timeout", ready, 1);
      node_id = nid;
      dnr     = d;
      len     = l;
      payload = p;
      v       = 1'b1;
   endtask

   task automatic send(input string name, input logic [1:0] nid, input logic d, input logic [3:0] l,
                       input logic [14:0] p, input logic [31:0] exp_bits, input int n);
      drive(nid, d, l, p);
      tick();
      // inputs after acceptance must not matter
      v       = 1'b0;
      node_id = ~nid;
      dnr     = ~d;
      len     = ~l;
      payload = ~p;
      check_stream(name, exp_bits, n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      v       = 1'b0;
      node_id = '0;
      dnr     = 1'b0;
      len     = '0;
      payload = '0;
      repeat (3) tick();
      chk("rst_tag", tag, 0);
      chk("rst_rdy", ready, 0);
      chk("rst_done", init_done, 0);
      chk("rst_busy", busy, 1);

      reset_n = 1'b1;
      check_init("init0");

      // node 2, dnr 1, len 3, payload 101 -> 1,0,1,1,1,1,0,0,1,0,1
      send("p_len3", 2'd2, 1'b1, 4'd3, 15'b101, 32'b10100111101, 11);
      // header only; payload bits must not appear -> 1,1,1,0,0,0,0,0
      send("p_len0", 2'd3, 1'b0, 4'd0, 15'h7FFF, 32'b00000111, 8);
      // full payload: 1,1,0,1,1,1,1,1 then 15 ones
      send("p_len15", 2'd1, 1'b1, 4'd15, 15'h7FFF, 32'h7FFFFB, 23);
      // upper payload bits ignored: 1,0,0,1,0,1,0,0,0,1
      send("p_mask", 2'd0, 1'b1, 4'd2, 15'h7FFE, 32'h229, 10);

      // v held with two packets queued: second start bit N+3 cycles after the first
      drive(2'd2, 1'b1, 4'd3, 15'b101);
      tick();
      node_id = 2'd3;
      dnr     = 1'b0;
      len     = 4'd0;
      payload = 15'h1234;
      check_stream("b2b_a", 32'b10100111101, 11);
      tick();
      v = 1'b0;
      check_stream("b2b_b", 32'b00000111, 8);

      // reset during bit 5 aborts; v held through re-init must wait for ready
      drive(2'd2, 1'b1, 4'd3, 15'b101);
      tick();
      v = 1'b0;
      repeat (4) tick();
      chk("mid_b4", tag, 1);
      reset_n = 1'b0;
      tick();
      chk("abort_tag", tag, 0);
      chk("abort_rdy", ready, 0);
      chk("abort_busy", busy, 1);
      chk("abort_done", init_done, 0);
      reset_n = 1'b1;
      node_id = 2'd3;
      dnr     = 1'b0;
      len     = 4'd0;
      payload = '0;
      v       = 1'b1;
      check_init("init1");
      tick();
      v = 1'b0;
      check_stream("post_rst", 32'b00000111, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
      $finish;
   end

endmodule

// File: doc/bsg_tag_serial_driver.md
Name: bsg_tag_serial_driver

Overview:
- Upstream feeder for the clock-generator pearl's bsg_tag input.
- Accepts whole tag packets over a valid/ready interface and serializes them onto a single tag data line, one bit per clock.
- On reset it emits the bsg_tag master initialization pattern; tag_data_o is then wired to the pearl's tag_data_i, and clk_i drives the pearl's tag_clk_i.
- Used by on-chip bring-up logic and by testbenches to program oscillator, downsampler, select and reset tag clients.

Parameters:
- els_p, 16, number of tag clients addressable; node id width nw = `BSG_SAFE_CLOG2(els_p).
- lg_width_p, 4, width of the packet length field; max payload mp = 2^lg_width_p - 1 bits.
- init_ones_p, 64, number of consecutive 1 bits emitted after reset to reset the tag master.
- init_zeros_p, 16, number of 0 bits emitted after the ones, before the first packet.
- gap_p, 2, minimum number of idle 0 bits between packets (must be >= 1).

Ports:
- clk_i, in, 1, sole clock; also the tag clock seen downstream.
- reset_n_i, in, 1, synchronous active-low reset.
- v_i, in, 1, packet valid.
- ready_and_o, out, 1, packet accepted when v_i & ready_and_o.
- node_id_i, in, nw, destination tag client.
- data_not_reset_i, in, 1, 1 = data packet, 0 = client reset packet.
- len_i, in, lg_width_p, payload bit count (0..mp).
- payload_i, in, mp, payload; bits [len_i-1:0] are sent, upper bits ignored.
- tag_data_o, out, 1, serial tag stream (registered).
- init_done_o, out, 1, high once the init pattern has completed.
- busy_o, out, 1, high in any state other than eIDLE.

Behaviour:
- Clock and reset: one clock (clk_i). Reset is synchronous and active-low on reset_n_i, sampled at the rising edge of clk_i.
- While reset_n_i == 0: tag_data_o = 0, ready_and_o = 0, init_done_o = 0, busy_o = 1, FSM = eINIT_ONES, counter = 0, shift register = 0.
- Reset asserted mid-packet aborts the packet immediately. The next cycle restarts the init pattern, which also resynchronizes the downstream master.
- All outputs are registered except ready_and_o, which is decoded from state (ready_and_o = state==eIDLE).
- eINIT_ONES: tag_data_o = 1 for exactly init_ones_p cycles, then go to eINIT_ZEROS.
- eINIT_ZEROS: tag_data_o = 0 for init_zeros_p cycles, then go to eIDLE. init_done_o rises on the eIDLE entry cycle and stays high until the next reset.
- eIDLE: tag_data_o = 0 and ready_and_o = 1. On v_i:
  - Load the shift register with the packet, LSB-first in this order: start bit 1, node_id_i[0..nw-1], data_not_reset_i, len_i[0..lg_width_p-1], payload_i[0..len_i-1].
  - Load bit count N = 2 + nw + lg_width_p + len_i.
  - Go to eSHIFT.
- eSHIFT:
  - tag_data_o = shift register bit 0 each cycle; shift right, decrement count.
  - After exactly N bits go to eGAP.
  - The start bit appears on tag_data_o in the cycle after acceptance (latency 1).
- eGAP: tag_data_o = 0 for gap_p cycles, then go to eIDLE.
  - Back-to-back packets: minimum start-to-start spacing is N + gap_p + 1 cycles.
- len_i == 0: legal; header only, N = 2 + nw + lg_width_p.
- len_i == mp: full payload; the shift register width is 2 + nw + lg_width_p + mp and must not overflow.
- Inputs are sampled only on the accept cycle. Changes to v_i or data at any other time are ignored.
- v_i held during init or shift: no acceptance until eIDLE.
- Counter width: clog2 of max(init_ones_p, init_zeros_p, gap_p, 2+nw+lg_width_p+mp) + 1, saturating never required.

Decomposition:
- bsg_tag_serial_driver_pkg holds:
  - state enum (eINIT_ONES, eINIT_ZEROS, eIDLE, eSHIFT, eGAP);
  - packed struct bsg_tag_serial_pkt_s {payload, len, data_not_reset, node_id};
  - header-width localparam function.
- No sub-module is needed. The shift register and counter are inline, in a single flat module.

Test Plan (els_p=4 → nw=2, lg_width_p=4, init_ones_p=8, init_zeros_p=4, gap_p=2):
- Release reset → tag_data_o = 1 for cycles 1–8, 0 for cycles 9–12; ready_and_o and init_done_o rise at cycle 13.
- Send node 2, dnr=1, len=3, payload=3'b101 → tag_data_o sequence 1,0,1,1,1,1,0,0,1,0,1 (11 bits), then 0,0; ready_and_o returns after the 2-cycle gap.
- Send len=0, node 3, dnr=0 → 8 bits: 1,1,1,0,0,0,0,0; no payload bits follow.
- Send len=15, payload all ones → 23-bit packet with 15 trailing 1s; no bit is lost or duplicated.
- Keep v_i high with two queued packets → second start bit exactly N+3 cycles after the first start bit; ready_and_o is low throughout.
- Pull reset_n_i low during bit 5 of a packet → next cycle tag_data_o = 0; after release the full 8-ones/4-zeros init repeats before ready_and_o rises.
